// File: rtl/sumador_serial.sv
// rtl/sumador_serial.sv - bit-serial unsigned adder, LSB first, one full-adder cell
// Operands load on start, one sum bit per clock, result and carry published with a one-cycle valido.
module sumador_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ocupado,
    output logic             valido,
    output logic [WIDTH-1:0] Resultado,
    output logic             Carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUMA = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             r_ocupado;
    logic             r_valido;
    logic [WIDTH-1:0] r_resultado;
    logic             r_carry;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c        = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};
    assign w_last     = (r_state == S_SUMA) && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SUMA;
            S_SUMA:  if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ocupado <= 1'b0;
            r_valido  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ocupado <= (w_next != S_IDLE);
            r_valido  <= (w_next == S_FIN);
        end
    end

    // Result registers move only on the completion edge so they hold across later operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_resultado <= '0;
            r_carry     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_sum <= '0;
                        r_c   <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_SUMA: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_sum <= w_sum_next;
                    r_c   <= w_c;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_resultado <= w_sum_next;
                        r_carry     <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ocupado   = r_ocupado;
    assign valido    = r_valido;
    assign Resultado = r_resultado;
    assign Carry     = r_carry;

endmodule
